// File: rtl/load_store_unit.sv
// RV32I load/store unit: one byte/half/word memory transaction per request, with
// wait-state handshake, load formatting, and misalign/illegal/timeout faults.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  fault,
    output logic [1:0]            fault_code,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        r_state;
    logic          r_isLoad;
    logic [2:0]    r_funct3;
    logic [1:0]    r_byteOff;
    logic [CW-1:0] r_count;
    logic          r_holdDone;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadFmt;

    assign w_accept = start && (r_state == IDLE) && (is_load ^ is_store);

    // Decode the incoming request: legality, alignment and store lane placement.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_mask     = 4'b1111;
        w_wdata    = store_data;
        if (is_load) begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                          funct3 == 3'b100 || funct3 == 3'b101);
        end else begin
            w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end
        case (funct3[1:0])
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = (addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_mask  = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Pick the addressed byte/half lane from the returned word and extend it.
    always_comb begin
        case (r_byteOff)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_byteOff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadFmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadFmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadFmt = {24'h0, w_byte};
            3'b101:  w_loadFmt = {16'h0, w_half};
            default: w_loadFmt = mem_rdata;
        endcase
    end

    // Transaction FSM; a fault found at accept spends an extra RESP cycle before done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_isLoad   <= 1'b0;
            r_funct3   <= 3'b000;
            r_byteOff  <= 2'b00;
            r_count    <= '0;
            r_holdDone <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            load_data  <= 32'h0;
            mem_addr   <= '0;
            mem_rstrb  <= 1'b0;
            mem_wmask  <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        busy       <= 1'b1;
                        r_isLoad   <= is_load;
                        r_funct3   <= funct3;
                        r_byteOff  <= addr[1:0];
                        r_count    <= '0;
                        fault_code <= 2'b00;
                        if (w_illegal || w_misalign) begin
                            fault_code <= w_illegal ? 2'b10 : 2'b01;
                            r_holdDone <= 1'b1;
                            r_state    <= RESP;
                        end else begin
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_rstrb <= is_load;
                            if (is_store) begin
                                mem_wmask <= w_mask;
                                mem_wdata <= w_wdata;
                            end
                            r_state <= REQ;
                        end
                    end
                end
                REQ: r_state <= WAIT;
                WAIT: begin
                    if (mem_ready) begin
                        if (r_isLoad) begin
                            load_data <= w_loadFmt;
                        end
                        done    <= 1'b1;
                        r_state <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && r_count == LAST) begin
                        fault_code <= 2'b11;
                        done       <= 1'b1;
                        fault      <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                RESP: begin
                    if (r_holdDone) begin
                        r_holdDone <= 1'b0;
                        done       <= 1'b1;
                        fault      <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
